// File: rtl/traffic_light_ctrl_n.sv
// N-approach signalised junction controller: round-robin GREEN/AMBER/ALL_RED with
// demand-driven green extension/early termination and a maintenance flashing-amber mode.

module traffic_light_lane (
  input  logic [1:0] phase,
  input  logic       sel,
  input  logic       tog,
  output logic       red,
  output logic       amber,
  output logic       green
);
  always_comb begin
    red   = 1'b1;
    amber = 1'b0;
    green = 1'b0;
    unique case (phase)
      2'd1:    begin green = sel; red = ~sel; end
      2'd2:    begin amber = sel; red = ~sel; end
      2'd3:    begin amber = tog; red = 1'b0; end
      default: red = 1'b1;
    endcase
  end
endmodule

module traffic_light_ctrl_n #(
  parameter int N_DIR     = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 60,
  parameter int MIN_GREEN = 15,
  parameter int AMBER_T   = 5,
  parameter int ALLRED_T  = 2,
  parameter int FLASH_T   = 30,
  localparam int DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIR-1:0] req,
  input  logic             flash_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] amber,
  output logic [N_DIR-1:0] green,
  output logic [DIR_W-1:0] active_dir,
  output logic [1:0]       phase
);
  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_AMBER  = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  typedef struct packed {
    phase_e           ph;
    logic [DIR_W-1:0] dir;
    logic [CNT_W-1:0] cnt;
    logic             tog;
  } state_t;

  state_t st_q, st_d;

  logic [DIR_W-1:0] nxt_dir;
  logic [N_DIR-1:0] own;
  logic             found, others, zero, min_ok, early;

  // Round-robin search starting one past the current owner; the owner is checked last.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    nxt_dir = st_q.dir;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = int'(st_q.dir) + k;
      if (idx >= N_DIR) idx = idx - N_DIR;
      if (!found && req[idx]) begin
        found   = 1'b1;
        nxt_dir = DIR_W'(idx);
      end
    end
  end

  always_comb begin
    own           = '0;
    own[st_q.dir] = 1'b1;
  end

  assign others = |(req & ~own);
  assign zero   = (st_q.cnt == '0);
  // elapsed >= MIN_GREEN-1, rewritten against the down-counter
  assign min_ok = (st_q.cnt <= CNT_W'(GREEN_T - MIN_GREEN));
  assign early  = min_ok && !req[st_q.dir] && others;

  always_ff @(posedge clk) begin
    if (!reset) st_q <= '{ph: PH_ALLRED, dir: '0, cnt: CNT_W'(ALLRED_T - 1), tog: 1'b0};
    else        st_q <= st_d;
  end

  always_comb begin
    st_d     = st_q;
    // every branch reloads at zero, so this decrement never wraps
    st_d.cnt = st_q.cnt - CNT_W'(1);
    if (flash_en) begin
      if (st_q.ph != PH_FLASH) begin
        st_d.ph  = PH_FLASH;
        st_d.cnt = CNT_W'(FLASH_T - 1);
        st_d.tog = 1'b1;
      end else if (zero) begin
        st_d.cnt = CNT_W'(FLASH_T - 1);
        st_d.tog = ~st_q.tog;
      end
    end else begin
      unique case (st_q.ph)
        PH_FLASH: begin
          st_d.ph  = PH_ALLRED;
          st_d.cnt = CNT_W'(ALLRED_T - 1);
          st_d.tog = 1'b0;
        end
        PH_ALLRED: if (zero) begin
          st_d.ph  = PH_GREEN;
          st_d.dir = nxt_dir;
          st_d.cnt = CNT_W'(GREEN_T - 1);
        end
        PH_GREEN: begin
          if (early || (zero && others)) begin
            st_d.ph  = PH_AMBER;
            st_d.cnt = CNT_W'(AMBER_T - 1);
          end else if (zero) begin
            st_d.cnt = CNT_W'(GREEN_T - 1);
          end
        end
        PH_AMBER: if (zero) begin
          st_d.ph  = PH_ALLRED;
          st_d.cnt = CNT_W'(ALLRED_T - 1);
        end
        default: st_d = st_q;
      endcase
    end
  end

  always_comb begin
    phase      = st_q.ph;
    active_dir = st_q.dir;
  end

  for (genvar i = 0; i < N_DIR; i++) begin : g_lane
    traffic_light_lane u_lane (
      .phase (st_q.ph),
      .sel   (st_q.dir == DIR_W'(i)),
      .tog   (st_q.tog),
      .red   (red[i]),
      .amber (amber[i]),
      .green (green[i])
    );
  end
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed table plus hand sequences for traffic_light_ctrl_n, then a random-demand soak
// checking lamp exclusivity and bounded waiting.

module tb_traffic_light_ctrl_n;
  logic       clk, reset, flash_en;
  logic [3:0] req, red, amber, green;
  logic [1:0] active_dir, phase;

  int n_chk  = 0;
  int n_fail = 0;

  traffic_light_ctrl_n #(
    .N_DIR(4), .CNT_W(8), .GREEN_T(8), .MIN_GREEN(3),
    .AMBER_T(2), .ALLRED_T(1), .FLASH_T(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flash_en   (flash_en),
    .red        (red),
    .amber      (amber),
    .green      (green),
    .active_dir (active_dir),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ncyc;
    bit         rst;
    logic [3:0] req;
    logic [1:0] ph;
    logic [1:0] dir;
    logic [3:0] r;
    logic [3:0] a;
    logic [3:0] g;
  } vec_t;

  vec_t tbl[12];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [1:0] ph, input logic [1:0] dir,
                     input logic [3:0] r, input logic [3:0] a, input logic [3:0] g);
    n_chk++;
    if ({phase, active_dir, red, amber, green} !== {ph, dir, r, a, g}) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d dir=%0d r=%b a=%b g=%b, want ph=%0d dir=%0d r=%b a=%b g=%b",
               name, phase, active_dir, red, amber, green, ph, dir, r, a, g);
    end
  endtask

  int wt[4];

  initial begin
    reset = 1'b0; req = '0; flash_en = 1'b0;

    // rest-in-green with no demand, then full round robin with constant demand
    tbl[0]  = '{2,  1'b1, 4'b0000, 2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000};
    tbl[1]  = '{1,  1'b0, 4'b0000, 2'd1, 2'd0, 4'b1110, 4'b0000, 4'b0001};
    tbl[2]  = '{20, 1'b0, 4'b0000, 2'd1, 2'd0, 4'b1110, 4'b0000, 4'b0001};
    tbl[3]  = '{2,  1'b1, 4'b1111, 2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000};
    tbl[4]  = '{1,  1'b0, 4'b1111, 2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010};
    tbl[5]  = '{7,  1'b0, 4'b1111, 2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010};
    tbl[6]  = '{1,  1'b0, 4'b1111, 2'd2, 2'd1, 4'b1101, 4'b0010, 4'b0000};
    tbl[7]  = '{1,  1'b0, 4'b1111, 2'd2, 2'd1, 4'b1101, 4'b0010, 4'b0000};
    tbl[8]  = '{1,  1'b0, 4'b1111, 2'd0, 2'd1, 4'b1111, 4'b0000, 4'b0000};
    tbl[9]  = '{1,  1'b0, 4'b1111, 2'd1, 2'd2, 4'b1011, 4'b0000, 4'b0100};
    tbl[10] = '{11, 1'b0, 4'b1111, 2'd1, 2'd3, 4'b0111, 4'b0000, 4'b1000};
    tbl[11] = '{11, 1'b0, 4'b1111, 2'd1, 2'd0, 4'b1110, 4'b0000, 4'b0001};

    for (int i = 0; i < 12; i++) begin
      reset = ~tbl[i].rst;
      req   = tbl[i].req;
      step(tbl[i].ncyc);
      chk($sformatf("vec%0d", i), tbl[i].ph, tbl[i].dir, tbl[i].r, tbl[i].a, tbl[i].g);
    end

    // early termination after minimum green, dir 3 skipped
    reset = 1'b0; req = 4'b0101; step(2);
    reset = 1'b1; step(1);
    chk("early_g0", 2'd1, 2'd2, 4'b1011, 4'b0000, 4'b0100);
    step(1);
    req = 4'b0001; step(1);
    chk("early_hold", 2'd1, 2'd2, 4'b1011, 4'b0000, 4'b0100);
    step(1);
    chk("early_amber", 2'd2, 2'd2, 4'b1011, 4'b0100, 4'b0000);
    step(2);
    chk("early_allred", 2'd0, 2'd2, 4'b1111, 4'b0000, 4'b0000);
    step(1);
    chk("early_next", 2'd1, 2'd0, 4'b1110, 4'b0000, 4'b0001);

    // flashing amber mid-green, then resume from the saved owner
    flash_en = 1'b1; step(1);
    chk("flash_on1", 2'd3, 2'd0, 4'b0000, 4'b1111, 4'b0000);
    step(1);
    chk("flash_on2", 2'd3, 2'd0, 4'b0000, 4'b1111, 4'b0000);
    step(1);
    chk("flash_off1", 2'd3, 2'd0, 4'b0000, 4'b0000, 4'b0000);
    step(1);
    chk("flash_off2", 2'd3, 2'd0, 4'b0000, 4'b0000, 4'b0000);
    step(1);
    chk("flash_on3", 2'd3, 2'd0, 4'b0000, 4'b1111, 4'b0000);
    flash_en = 1'b0; req = 4'b0110; step(1);
    chk("flash_exit", 2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000);
    step(1);
    chk("flash_resume", 2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010);

    // reset during amber of approach 3
    reset = 1'b0; req = 4'b1000; step(2);
    reset = 1'b1; step(1);
    chk("rst_g3", 2'd1, 2'd3, 4'b0111, 4'b0000, 4'b1000);
    req = 4'b0001; step(3);
    chk("rst_amber3", 2'd2, 2'd3, 4'b0111, 4'b1000, 4'b0000);
    reset = 1'b0; step(1);
    chk("rst_mid_amber", 2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000);
    reset = 1'b1; req = '0;

    // random slowly-varying demand soak
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      step(1);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || green[i] || active_dir == 2'(i)) wt[i] = 0;
        else wt[i]++;
      end
      n_chk++;
      if ($countones({green, amber}) > 1 ||
          (red & amber) != '0 || (red & green) != '0 || (amber & green) != '0 ||
          (red | amber | green) != 4'b1111 ||
          wt[0] > 33 || wt[1] > 33 || wt[2] > 33 || wt[3] > 33) begin
        n_fail++;
        $display("FAIL soak cyc %0d: r=%b a=%b g=%b wait=%0d/%0d/%0d/%0d, want exclusive lamps and wait<=33",
                 c, red, amber, green, wt[0], wt[1], wt[2], wt[3]);
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(15) == 0) req[i] = ~req[i];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
- Parametrised N-approach signalised-junction controller. Successor to the fixed 4-way sensor-driven controller.
- Each approach gets a timed GREEN -> AMBER -> ALL_RED sequence. Approaches with no demand are skipped round-robin.
- Green is extended or terminated early based on demand. A maintenance flashing-amber mode is added.
- Sits between the debounced vehicle-sensor bank and the lamp driver registers.

Parameters:
- N_DIR, 4, number of approaches (2..16).
- CNT_W, 8, width of the phase-timer down-counter.
- GREEN_T, 60, maximum green duration in cycles (1..2^CNT_W-1).
- MIN_GREEN, 15, minimum green duration in cycles before early termination is allowed (1..GREEN_T).
- AMBER_T, 5, amber duration in cycles.
- ALLRED_T, 2, all-red clearance duration in cycles.
- FLASH_T, 30, half-period of the flashing amber in cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- req  in  N_DIR  demand per approach; 1 = vehicle waiting or present. Synchronous to clk.
- flash_en  in  1  maintenance mode request; level-sensitive.
- red  out  N_DIR  red lamp per approach.
- amber  out  N_DIR  amber lamp per approach.
- green  out  N_DIR  green lamp per approach.
- active_dir  out  max(1,clog2(N_DIR))  index of the approach owning the current or most recent green.
- phase  out  2  current phase: 0 = ALL_RED, 1 = GREEN, 2 = AMBER, 3 = FLASH.

Behaviour:
- Moore machine. Outputs decode only registered state (phase, active_dir, flash toggle). There is no combinational path from inputs to outputs.
- Timer: on entry to a phase, the counter loads (T-1) for that phase. It decrements each cycle. The phase is left on the edge where the counter is 0, so each phase lasts exactly T cycles.
- Elapsed-green count = GREEN_T-1-counter.
- Reset (reset == 0 at an edge):
  - phase = ALL_RED, active_dir = 0, counter = ALLRED_T-1, flash toggle = 0.
  - Outputs: red = all ones, amber = 0, green = 0.
  - Reset mid-phase abandons that phase immediately.
- ALL_RED:
  - red = all ones.
  - At counter == 0, select the next approach: search indices active_dir+1 .. active_dir+N_DIR modulo N_DIR and take the first with req == 1. The current approach is checked last.
  - If no req is set, select active_dir.
  - Enter GREEN with the selected approach.
- GREEN:
  - green is one-hot at active_dir; red = ~green; amber = 0.
  - Early exit to AMBER when all hold: elapsed >= MIN_GREEN-1, req[active_dir] == 0, and any other req bit == 1.
  - At counter == 0: if any other approach has req == 1, go to AMBER. Otherwise stay in GREEN and reload GREEN_T-1 (rest-in-green).
- AMBER:
  - amber is one-hot at active_dir; red = ~amber; green = 0.
  - At counter == 0, go to ALL_RED.
- FLASH:
  - Entered from any phase on the first edge with flash_en == 1. The counter loads FLASH_T-1 and the toggle is set to 1.
  - amber = all toggle; red = 0; green = 0.
  - The toggle inverts each time the counter reaches 0, and the counter reloads.
  - On the first edge with flash_en == 0, go to ALL_RED with a full ALLRED_T. active_dir is unchanged.
- Priority: reset > flash_en > normal sequencing. flash_en wins over a phase expiry on the same edge.
- req changes mid-phase affect only the decisions listed above. Selection samples req on the deciding edge only.
- Safety invariant: at most one green or amber bit is set. In every non-FLASH phase, each approach has exactly one of red/amber/green set.
- Counter arithmetic is unsigned CNT_W bits and never underflows: reload takes priority at 0.

Test Plan:
- Params N_DIR=4, GREEN_T=8, MIN_GREEN=3, AMBER_T=2, ALLRED_T=1, FLASH_T=2 for all scenarios.
- Reset low 2 cycles, then high with req=0000 -> ALL_RED for 1 cycle, then GREEN dir 0 (green=0001, red=1110). It stays green indefinitely, reloading every 8 cycles.
- req=1111 constant from reset -> round-robin 1,2,3,0. Each cycle is GREEN 8, AMBER 2, ALL_RED 1 (11 cycles per approach).
- req=0101, dir 2 green: drop req[2] at elapsed 1 -> AMBER starts after green cycle 3, not before. Next green is dir 0 (dir 3 is skipped).
- flash_en asserted mid-GREEN -> next cycle: green=0, red=0, amber=1111 for 2 cycles, then 0000 for 2 cycles, repeating. Deassert -> ALL_RED for 1 cycle, then selection resumes from the saved active_dir.
- reset low during AMBER with active_dir=3 -> next edge: phase=0, active_dir=0, red=1111.
- Random req over 10k cycles -> the one-hot-green/amber assertion and the per-approach red/amber/green exclusivity assertion never fail. No approach with req held high waits longer than 3*(8+2+1) cycles.
